// File: rtl/gpu_host_driver.sv
// Host-side master for the CPU->GPU command bus. Each accepted request is
// serialised onto cpu_recv_instr/cpu_in_data as an opcode word followed by
// ARG words: address, count, then write data. The driver then waits for
// cpu_out_ack, either as a completion or as one strobe per read word.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   req_valid/req_ready           request handshake (op, addr, count)
//   wr_data_valid/wr_data         host write stream (push, one word per valid)
//   wr_data_ready                 pulse: a write word went onto the bus
//   rd_data_valid/rd_data         read word returned by the GPU
//   done, err                     completion / illegal-op-or-timeout pulses
//   cpu_recv_instr, cpu_in_data   bus toward GPU (0=NOP, 1..3 op, 4=ARG)
//   cpu_out_data, cpu_out_ack     response from GPU
//
// All outputs are registered. The state names the phase the bus is showing,
// so each state computes what the bus shows in the following cycle.
module gpu_host_driver #(
  parameter int unsigned data_width     = 32,
  parameter int unsigned count_width    = 16,
  parameter int unsigned timeout_cycles = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [1:0]             req_op,
  input  logic [data_width-1:0]  req_addr,
  input  logic [count_width-1:0] req_count,
  input  logic                   wr_data_valid,
  input  logic [data_width-1:0]  wr_data,
  output logic                   wr_data_ready,
  output logic                   rd_data_valid,
  output logic [data_width-1:0]  rd_data,
  output logic                   done,
  output logic                   err,
  output logic [31:0]            cpu_recv_instr,
  output logic [data_width-1:0]  cpu_in_data,
  input  logic [data_width-1:0]  cpu_out_data,
  input  logic                   cpu_out_ack
);

  localparam int unsigned TMO_W = $clog2(timeout_cycles);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(timeout_cycles - 1);
  localparam logic [31:0] BUS_NOP = 32'd0;
  localparam logic [31:0] BUS_ARG = 32'd4;
  localparam logic [1:0]  OP_FROM   = 2'd2;
  localparam logic [1:0]  OP_LAUNCH = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_INSTR, S_ADDR, S_COUNT, S_DATA, S_WAIT, S_RECV
  } state_t;

  state_t                 state_q, state_d;
  logic [1:0]             op_q, op_d;
  logic [data_width-1:0]  addr_q, addr_d;
  logic [count_width-1:0] count_q, count_d;
  logic [TMO_W-1:0]       tmo_q, tmo_d;
  logic [31:0]            instr_q, instr_d;
  logic [data_width-1:0]  in_data_q, in_data_d;
  logic [data_width-1:0]  rd_data_q, rd_data_d;
  logic                   req_ready_q, req_ready_d;
  logic                   wr_ready_q, wr_ready_d;
  logic                   rd_valid_q, rd_valid_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    count_d    = count_q;
    tmo_d      = tmo_q;
    instr_d    = BUS_NOP;
    in_data_d  = '0;
    rd_data_d  = rd_data_q;
    wr_ready_d = 1'b0;
    rd_valid_d = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (req_op == 2'd0) begin
            err_d = 1'b1;
          end else begin
            op_d    = req_op;
            addr_d  = req_addr;
            count_d = req_count;
            instr_d = 32'(req_op);
            state_d = S_INSTR;
          end
        end
      end
      S_INSTR: begin
        state_d   = S_ADDR;
        instr_d   = BUS_ARG;
        in_data_d = addr_q;
      end
      S_ADDR: begin
        if (op_q == OP_LAUNCH) begin
          state_d = S_WAIT;
          tmo_d   = '0;
        end else begin
          state_d   = S_COUNT;
          instr_d   = BUS_ARG;
          in_data_d = data_width'(count_q);
        end
      end
      // The first write word is sampled while the count is on the bus so
      // that data follows the count with no bubble.
      S_COUNT, S_DATA: begin
        if (op_q == OP_FROM) begin
          if (count_q == '0) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_RECV;
            tmo_d   = '0;
          end
        end else if (count_q == '0) begin
          state_d = S_WAIT;
          tmo_d   = '0;
        end else begin
          state_d = S_DATA;
          if (wr_data_valid) begin
            instr_d    = BUS_ARG;
            in_data_d  = wr_data;
            wr_ready_d = 1'b1;
            count_d    = count_q - count_width'(1);
          end
        end
      end
      S_WAIT: begin
        if (cpu_out_ack) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_RECV: begin
        if (cpu_out_ack) begin
          rd_valid_d = 1'b1;
          rd_data_d  = cpu_out_data;
          count_d    = count_q - count_width'(1);
          tmo_d      = '0;
          if (count_q == count_width'(1)) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    req_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      addr_q      <= '0;
      count_q     <= '0;
      tmo_q       <= '0;
      instr_q     <= '0;
      in_data_q   <= '0;
      rd_data_q   <= '0;
      req_ready_q <= 1'b1;
      wr_ready_q  <= 1'b0;
      rd_valid_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      tmo_q       <= tmo_d;
      instr_q     <= instr_d;
      in_data_q   <= in_data_d;
      rd_data_q   <= rd_data_d;
      req_ready_q <= req_ready_d;
      wr_ready_q  <= wr_ready_d;
      rd_valid_q  <= rd_valid_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign req_ready      = req_ready_q;
  assign wr_data_ready  = wr_ready_q;
  assign rd_data_valid  = rd_valid_q;
  assign rd_data        = rd_data_q;
  assign done           = done_q;
  assign err            = err_q;
  assign cpu_recv_instr = instr_q;
  assign cpu_in_data    = in_data_q;

endmodule
